// File: rtl/rx_package.sv
// Shared receive-path definitions: PRBS polynomial, counter widths and the
// checker FSM encoding. The TX generator imports the same constants so both
// ends of the link always agree on the polynomial.
package rx_package;

  // PRBS polynomial shared by TX generator and RX checker (x^7 + x^6 + 1)
  localparam int PRBS_ORDER = 7;
  localparam int PRBS_TAP   = 6;

  // Seed pattern the TX generator loads out of reset (any non-zero value works)
  localparam logic [PRBS_ORDER-1:0] PRBS_TX_SEED = '1;

  // Measurement counter widths
  localparam int ERR_COUNT_WIDTH = 32;
  localparam int BIT_COUNT_WIDTH = 48;

  // Emulated time stamp width
  localparam int TIME_WIDTH = 64;

  typedef logic [ERR_COUNT_WIDTH-1:0] ERR_COUNT_FORMAT;
  typedef logic [BIT_COUNT_WIDTH-1:0] BIT_COUNT_FORMAT;
  typedef logic [TIME_WIDTH-1:0]      TIME_FORMAT;

  // Checker synchronisation states
  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_check_state_t;

endpackage

// File: rtl/prbs_lfsr_step.sv
// One step of a Fibonacci PRBS LFSR: the feedback bit of the current state and
// the state after shifting a chosen bit in at the LSB. The caller decides what
// is shifted in (the feedback itself for generation, received data for seeding).
module prbs_lfsr_step
  import rx_package::*;
#(
  parameter int ORDER = PRBS_ORDER,
  parameter int TAP   = PRBS_TAP
) (
  input  logic [ORDER-1:0] state,
  input  logic             shift_in,
  output logic             feedback,
  output logic [ORDER-1:0] next_state
);

  // Kept as separate continuous assigns so a caller may route feedback back
  // into shift_in without forming a combinational loop through one block.
  assign feedback   = state[ORDER-1] ^ state[TAP-1];
  assign next_state = {state[ORDER-2:0], shift_in};

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker. Self-synchronises a local LFSR to the recovered
// bit stream, then counts checked bits and bit errors, drops back to seeding
// when a window shows too many errors, and stamps the time of the first lock.
module prbs_checker
  import rx_package::*;
#(
  parameter int PRBS_ORDER = rx_package::PRBS_ORDER,
  parameter int PRBS_TAP   = rx_package::PRBS_TAP,
  parameter int LOCK_COUNT = 32,
  parameter int WINDOW     = 256,
  parameter int LOL_THRESH = 32
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            cke_rx,
  input  logic            data_in,
  input  logic            clear,
  input  TIME_FORMAT      time_curr,
  output logic            locked,
  output logic            err_pulse,
  output ERR_COUNT_FORMAT err_count,
  output BIT_COUNT_FORMAT bit_count,
  output TIME_FORMAT      lock_time,
  output logic            lock_valid
);

  localparam int SEED_W = $clog2(PRBS_ORDER + 1);
  localparam int VER_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(WINDOW + 1);

  localparam logic [SEED_W-1:0] SEED_LAST   = SEED_W'(PRBS_ORDER - 1);
  localparam logic [VER_W-1:0]  VERIFY_LAST = VER_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]  WINDOW_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0]  LOL_LIMIT   = WIN_W'(LOL_THRESH);

  prbs_check_state_t     state;
  logic [PRBS_ORDER-1:0] lfsr;
  logic [PRBS_ORDER-1:0] lfsr_next;
  logic [SEED_W-1:0]     seed_cnt;
  logic [VER_W-1:0]      verify_cnt;
  logic [WIN_W-1:0]      win_bits;
  logic [WIN_W-1:0]      win_errs;
  logic [WIN_W-1:0]      win_errs_next;

  logic            predicted;
  logic            shift_bit;
  logic            mismatch;
  logic            window_end;
  logic            lose_lock;
  ERR_COUNT_FORMAT err_count_inc;
  BIT_COUNT_FORMAT bit_count_inc;

  // While locked the LFSR free-runs on its own prediction so a channel error
  // is counted once instead of corrupting the following predictions.
  assign shift_bit = (state == LOCKED) ? predicted : data_in;

  prbs_lfsr_step #(
    .ORDER (PRBS_ORDER),
    .TAP   (PRBS_TAP)
  ) u_step (
    .state      (lfsr),
    .shift_in   (shift_bit),
    .feedback   (predicted),
    .next_state (lfsr_next)
  );

  // Per-bit comparison, window bookkeeping and saturating counter increments
  always_comb begin
    mismatch      = data_in ^ predicted;
    window_end    = (win_bits == WINDOW_LAST);
    win_errs_next = win_errs + WIN_W'(mismatch);
    lose_lock     = window_end && (win_errs_next >= LOL_LIMIT);
    err_count_inc = (&err_count) ? err_count : err_count + ERR_COUNT_FORMAT'(1);
    bit_count_inc = (&bit_count) ? bit_count : bit_count + BIT_COUNT_FORMAT'(1);
  end

  // Synchronisation FSM with registered outputs; only strobed cycles advance it
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= SEED;
      lfsr       <= '0;
      seed_cnt   <= '0;
      verify_cnt <= '0;
      win_bits   <= '0;
      win_errs   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      bit_count  <= '0;
      lock_time  <= '0;
      lock_valid <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (cke_rx) begin
        lfsr <= lfsr_next;
        unique case (state)
          SEED: begin
            if (seed_cnt == SEED_LAST) begin
              seed_cnt <= '0;
              // An all-zero seed would predict zeros forever; reseed instead.
              if (lfsr_next != '0) begin
                state      <= VERIFY;
                verify_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + SEED_W'(1);
            end
          end
          VERIFY: begin
            if (mismatch) begin
              // The offending bit is already in the LFSR and counts as seed bit 1.
              state    <= SEED;
              seed_cnt <= SEED_W'(1);
            end else if (verify_cnt == VERIFY_LAST) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              win_bits <= '0;
              win_errs <= '0;
              if (!lock_valid) begin
                lock_valid <= 1'b1;
                lock_time  <= time_curr;
              end
            end else begin
              verify_cnt <= verify_cnt + VER_W'(1);
            end
          end
          LOCKED: begin
            bit_count <= bit_count_inc;
            if (mismatch) begin
              err_count <= err_count_inc;
              // The error that ends the lock is counted but not pulsed, so
              // err_pulse is never seen together with locked low.
              err_pulse <= !lose_lock;
            end
            if (window_end) begin
              win_bits <= '0;
              win_errs <= '0;
              if (lose_lock) begin
                state    <= SEED;
                locked   <= 1'b0;
                seed_cnt <= '0;
              end
            end else begin
              win_bits <= win_bits + WIN_W'(1);
              win_errs <= win_errs_next;
            end
          end
          default: begin
            state    <= SEED;
            locked   <= 1'b0;
            seed_cnt <= '0;
          end
        endcase
      end
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule
